mult_div_unit: RTL and testbench
================================

# mult_div_unit

Iterative 32-bit multiply/divide unit with architectural HI/LO registers, sitting beside the ALU on the operand path of the multi-cycle CPU. It consumes the same A/B operand registers the ALU reads, executes mult/multu/div/divu over 33 cycles, and provides HI/LO to the ALUOut/write-back mux for mfhi/mflo. The controller FSM stalls on `busy` and resumes on `done`.

## Interface
- `WIDTH`, 32, operand width; only 32 is supported.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  launch operation; sampled only in IDLE
- `op`  in  2  00 mult, 01 multu, 10 div, 11 divu
- `In1`  in  32  rs operand (multiplicand / dividend)
- `In2`  in  32  rt operand (multiplier / divisor)
- `hi_we`  in  1  mthi write strobe
- `lo_we`  in  1  mtlo write strobe
- `wdata`  in  32  mthi/mtlo data
- `busy`  out  1  operation in progress
- `done`  out  1  one-cycle pulse: HI/LO hold the new result
- `Hi`  out  32  HI register
- `Lo`  out  32  LO register

## Operation
- States: IDLE, MUL, DIV, FIX.
- IDLE with `start`=1:
  - Latch `|In1|`, `|In2|` (absolute value for signed ops, raw for unsigned).
  - Latch result-sign flags:
    - Multiply: product sign = sign(In1) xor sign(In2).
    - Divide: quotient sign = sign(In1) xor sign(In2); remainder sign = sign(In1).
  - Clear the 5-bit counter. Go to MUL (op[1]=0) or DIV (op[1]=1).
- MUL: shift-add, one multiplier bit per cycle, into a 64-bit accumulator. After 32 iterations go to FIX.
- DIV: restoring division, one quotient bit per cycle, 33-bit partial remainder. After 32 iterations go to FIX.
- FIX:
  - Apply two's-complement negation per the sign flags.
  - Multiply: write {Hi,Lo} = 64-bit product.
  - Divide: write Hi = remainder, Lo = quotient.
  - Pulse `done`. Return to IDLE.
- Divide by zero: no trap. Result is Lo = 32'hFFFFFFFF and Hi = In1, for signed and unsigned ops alike. The iteration still runs full length; the result is forced in FIX.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: Lo = 0x80000000, Hi = 0. This falls out of the magnitude algorithm and must not be special-cased.
- mthi/mtlo: in IDLE, the write takes effect at the next edge. While `busy`=1, writes are ignored. `hi_we` and `lo_we` may be asserted together.
- `start` while `busy`=1 is ignored. The operation in flight is unaffected.
- `start` and `hi_we`/`lo_we` together in IDLE: the move write takes effect. The operation then overwrites HI/LO in FIX.
- Operands are sampled only at the start edge. `In1`/`In2` may change afterwards.

## Timing
- Reset (async assert, sync release): state = IDLE, `busy`=0, `done`=0, Hi = Lo = 0, counter = 0.
- A reset asserted mid-operation aborts it; HI/LO clear to 0.
- Edge E0 samples `start`. `busy`=1 from after E0 until E33.
- E1–E32 are the iteration edges. E33 is the FIX edge: HI/LO update and `done`=1 for exactly the cycle following E33, with `busy`=0 in that same cycle.
- Latency is 33 cycles from start to result, identical for all ops including divide by zero.
- A new `start` is accepted in the `done` cycle (back-to-back operations).
- `Hi`/`Lo` are direct register outputs, with no combinational path from the inputs.

## Structure
- Shared package `md_pkg`:
  - op encodings `MD_MULT`, `MD_MULTU`, `MD_DIV`, `MD_DIVU`
  - state typedef `md_state_t`
  - `MD_ITER = 32`
- Single module. The datapath is one 64-bit accumulator/remainder register plus a 32-bit operand register, shared between MUL and DIV. No sub-module is warranted.

## Test plan
- multu 0xFFFFFFFF × 0xFFFFFFFF → after 33 cycles Hi = 0xFFFFFFFE, Lo = 0x00000001, `done` high for one cycle.
- mult −3 (0xFFFFFFFD) × 7 → Hi = 0xFFFFFFFF, Lo = 0xFFFFFFEB; the same operands with multu give Hi = 0x00000006, Lo = 0xFFFFFFEB.
- div −7 ÷ 2 → Lo = 0xFFFFFFFD (−3), Hi = 0xFFFFFFFF (−1); divu 100 ÷ 7 → Lo = 14, Hi = 2.
- divu 0x1234 ÷ 0 → Lo = 0xFFFFFFFF, Hi = 0x1234; div 0x80000000 ÷ 0xFFFFFFFF → Lo = 0x80000000, Hi = 0.
- Second `start` and `hi_we` (wdata = 0xDEAD) at cycle 10 of a mult → both ignored, result correct; the same mthi in IDLE → Hi = 0xDEAD next cycle, Lo unchanged.
- Reset low at cycle 20 of a div → Hi = Lo = 0, `busy`=0 immediately; after release, a new multu 5 × 6 gives Lo = 30, Hi = 0.

Source files
------------

// File: rtl/md_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
package md_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    localparam int MD_ITER = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MUL  = 2'b01,
        S_DIV  = 2'b10,
        S_FIX  = 2'b11
    } md_state_t;

    // Magnitude of a 32-bit value; neg selects two's-complement negation.
    function automatic logic [31:0] md_abs(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Iterative 32-bit mult/multu/div/divu with architectural HI/LO registers.
// One 64-bit acc register is shared: shift-add product for MUL, and
// {partial remainder, dividend/quotient} for restoring DIV.
module mult_div_unit
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] In1,
    input  logic [WIDTH-1:0] In2,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    md_state_t   state, state_nxt;
    logic [4:0]  cnt;
    logic [63:0] acc;
    logic [31:0] opr;
    logic        q_neg, r_neg, dz, is_div;

    // Operand sign decode at the start edge; unsigned ops never negate.
    logic        op_sgn, a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    assign op_sgn = ~op[0];
    assign a_neg  = op_sgn & In1[31];
    assign b_neg  = op_sgn & In2[31];
    assign a_mag  = md_abs(In1, a_neg);
    assign b_mag  = md_abs(In2, b_neg);

    logic last;
    assign last = (cnt == 5'(MD_ITER - 1));

    // Shift-add step: add multiplicand when the current multiplier bit is set.
    logic [32:0] mul_sum;
    logic [63:0] mul_nxt;
    assign mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opr} : 33'd0);
    assign mul_nxt = {mul_sum, acc[31:1]};

    // Restoring step: the 33-bit partial remainder is acc[63:31].
    logic        div_ok;
    logic [31:0] div_sub;
    logic [63:0] div_nxt;
    assign div_ok  = acc[63] | (acc[62:31] >= opr);
    assign div_sub = acc[62:31] - opr;
    assign div_nxt = div_ok ? {div_sub, acc[30:0], 1'b1} : {acc[62:0], 1'b0};

    // Sign fix-up. With a zero divisor every trial subtract succeeds, so the
    // remainder half ends up holding |In1| and sign-fixing restores In1; only
    // the quotient needs forcing.
    logic [63:0] prod_fix;
    logic [31:0] rem_fix, quo_fix;
    assign prod_fix = q_neg ? (~acc + 64'd1) : acc;
    assign rem_fix  = md_abs(acc[63:32], r_neg);
    assign quo_fix  = dz ? 32'hFFFF_FFFF : md_abs(acc[31:0], q_neg);

    assign busy = (state != S_IDLE);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state: launch from IDLE, 32 iterations, one fix-up cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = op[1] ? S_DIV : S_MUL;
            S_MUL:  if (last)  state_nxt = S_FIX;
            S_DIV:  if (last)  state_nxt = S_FIX;
            S_FIX:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath, HI/LO and done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            acc    <= '0;
            opr    <= '0;
            q_neg  <= 1'b0;
            r_neg  <= 1'b0;
            dz     <= 1'b0;
            is_div <= 1'b0;
            done   <= 1'b0;
            Hi     <= '0;
            Lo     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (hi_we) Hi <= wdata;
                    if (lo_we) Lo <= wdata;
                    if (start) begin
                        acc    <= {32'd0, op[1] ? a_mag : b_mag};
                        opr    <= op[1] ? b_mag : a_mag;
                        q_neg  <= a_neg ^ b_neg;
                        r_neg  <= a_neg;
                        dz     <= (In2 == '0);
                        is_div <= op[1];
                        cnt    <= '0;
                    end
                end
                S_MUL: begin
                    acc <= mul_nxt;
                    cnt <= cnt + 5'd1;
                end
                S_DIV: begin
                    acc <= div_nxt;
                    cnt <= cnt + 5'd1;
                end
                S_FIX: begin
                    if (is_div) begin
                        Hi <= rem_fix;
                        Lo <= quo_fix;
                    end else begin
                        Hi <= prod_fix[63:32];
                        Lo <= prod_fix[31:0];
                    end
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit.
module tb_mult_div_unit;
    import md_pkg::*;

    logic        clk, reset, start, hi_we, lo_we;
    logic [1:0]  op;
    logic [31:0] In1, In2, wdata;
    logic        busy, done;
    logic [31:0] Hi, Lo;

    int passed = 0;
    int total  = 0;
    int failed = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .In1(In1), .In2(In2), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .Hi(Hi), .Lo(Lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Launch at a negedge, walk to the done cycle, check timing and result.
    task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        start = 1'b1; op = o; In1 = a; In2 = b;
        @(negedge clk);
        start = 1'b0; In1 = 32'h5A5A_5A5A; In2 = 32'hA5A5_A5A5;
        check({tag, " busy@E0"}, 32'(busy), 32'd1);
        check({tag, " done@E0"}, 32'(done), 32'd0);
        repeat (32) @(negedge clk);
        check({tag, " busy@E32"}, 32'(busy), 32'd1);
        check({tag, " done@E32"}, 32'(done), 32'd0);
        @(negedge clk);
        check({tag, " done@E33"}, 32'(done), 32'd1);
        check({tag, " busy@E33"}, 32'(busy), 32'd0);
        check({tag, " Hi"}, Hi, eh);
        check({tag, " Lo"}, Lo, el);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = MD_MULT; In1 = '0; In2 = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        #2 reset = 1'b0;
        @(negedge clk);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst Hi", Hi, 32'd0);
        check("rst Lo", Lo, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Back-to-back: each do_op launches in the previous op's done cycle.
        do_op("multu max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        do_op("mult -3x7", MD_MULT,  32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        do_op("multu -3x7", MD_MULTU, 32'hFFFF_FFFD, 32'd7, 32'h0000_0006, 32'hFFFF_FFEB);
        do_op("div -7/2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        do_op("divu 100/7", MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
        do_op("divu /0", MD_DIVU, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF);
        do_op("div -5/0", MD_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
        do_op("div ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
        @(negedge clk);
        check("idle done", 32'(done), 32'd0);

        // Start + mthi during an op in flight are ignored.
        start = 1'b1; op = MD_MULT; In1 = 32'hFFFF_FFFD; In2 = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        start = 1'b1; op = MD_DIVU; In1 = 32'd9; In2 = 32'd3; hi_we = 1'b1; wdata = 32'h0000_DEAD;
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0;
        check("busy mid", 32'(busy), 32'd1);
        repeat (23) @(negedge clk);
        check("ign done", 32'(done), 32'd1);
        check("ign Hi", Hi, 32'hFFFF_FFFF);
        check("ign Lo", Lo, 32'hFFFF_FFEB);
        @(negedge clk);
        check("ign busy after", 32'(busy), 32'd0);

        // mthi in IDLE, then mthi+mtlo together.
        hi_we = 1'b1; wdata = 32'h0000_DEAD;
        @(negedge clk);
        hi_we = 1'b0;
        check("mthi Hi", Hi, 32'h0000_DEAD);
        check("mthi Lo", Lo, 32'hFFFF_FFEB);
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1111_2222;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        check("mthilo Hi", Hi, 32'h1111_2222);
        check("mthilo Lo", Lo, 32'h1111_2222);

        // Reset mid-divide aborts and clears HI/LO.
        start = 1'b1; op = MD_DIV; In1 = 32'hFFFF_FFF9; In2 = 32'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort busy", 32'(busy), 32'd0);
        check("abort Hi", Hi, 32'd0);
        check("abort Lo", Lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        do_op("multu 5x6", MD_MULTU, 32'd5, 32'd6, 32'd0, 32'd30);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
